// File: rtl/equ1_frame_seq_if.sv
// Pixel stream into the equ1 frame sequencer: valid/ready handshake plus raster-order pixel.
// The master is the pixel source, the slave is the sequencer.
interface equ1_frame_seq_if #(
  parameter int PW = 12
);
  logic          in_valid;
  logic          in_ready;
  logic [PW-1:0] in_pix;

  modport master (output in_valid, output in_pix, input in_ready);
  modport slave  (input in_valid, input in_pix, output in_ready);
endinterface

// File: rtl/equ1_frame_seq.sv
// Streaming sequencer for the equ1 gradient datapath: 4 line buffers + 5x5 window feed equ1,
// and a LAT-deep valid/coordinate delay line tags each returned gradient with its centre pixel.
module equ1_frame_seq #(
  parameter int IMG_W = 8,
  parameter int IMG_H = 6,
  parameter int PW    = 12,
  parameter int LAT   = 3,
  parameter int CW    = 10
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               frame_start,
  equ1_frame_seq_if.slave    pix,
  output logic               eq_start,
  output logic [25*PW-1:0]   eq_win,
  input  logic [7:0]         eq_grad,
  output logic               grad_valid,
  output logic [7:0]         grad_out,
  output logic [CW-1:0]      grad_x,
  output logic [CW-1:0]      grad_y,
  output logic               busy,
  output logic               frame_done
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam int XW = (IMG_W > 1) ? $clog2(IMG_W) : 1;

  logic [1:0]    state;
  logic [CW-1:0] col;
  logic [CW-1:0] row;

  logic [PW-1:0] lb  [4][IMG_W];
  logic [PW-1:0] win [5][5];
  logic [PW-1:0] new_col [5];

  logic [LAT-1:0] dv;
  logic [CW-1:0]  dx [LAT];
  logic [CW-1:0]  dy [LAT];

  logic          accept;
  logic          start_next;
  logic          col_last;
  logic          row_last;
  logic          pipe_busy_next;
  logic [XW-1:0] col_idx;
  logic [1:0]    slot;

  assign accept         = (state == S_RUN) && pix.in_valid;
  assign col_last       = (col == CW'(IMG_W - 1));
  assign row_last       = (row == CW'(IMG_H - 1));
  assign start_next     = accept && (col >= CW'(4)) && (row >= CW'(4));
  assign pipe_busy_next = start_next || (|dv);
  assign col_idx        = col[XW-1:0];
  assign slot           = row[1:0];

  assign pix.in_ready = (state == S_RUN);
  assign busy         = (state == S_RUN) || (state == S_DRAIN);
  assign frame_done   = (state == S_DONE);

  // Line j lives in slot j%4, so slot (row+k)%4 holds line row-4+k; slot row%4 is the oldest.
  always_comb begin
    for (int r = 0; r < 4; r++) begin
      new_col[r] = lb[slot + 2'(r)][col_idx];
    end
    new_col[4] = pix.in_pix;
  end

  always_comb begin
    eq_win = '0;
    for (int r = 0; r < 5; r++) begin
      for (int c = 0; c < 5; c++) begin
        eq_win[(r*5+c)*PW +: PW] = win[r][c];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      lb[slot][col_idx] <= pix.in_pix;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= S_IDLE;
      col        <= '0;
      row        <= '0;
      eq_start   <= 1'b0;
      dv         <= '0;
      grad_valid <= 1'b0;
      grad_out   <= '0;
      grad_x     <= '0;
      grad_y     <= '0;
      for (int i = 0; i < LAT; i++) begin
        dx[i] <= '0;
        dy[i] <= '0;
      end
      for (int r = 0; r < 5; r++) begin
        for (int c = 0; c < 5; c++) begin
          win[r][c] <= '0;
        end
      end
    end else begin
      eq_start <= start_next;

      // dv[0] mirrors eq_start; the output register adds the final cycle of latency.
      dv[0] <= start_next;
      dx[0] <= col - CW'(2);
      dy[0] <= row - CW'(2);
      for (int i = 1; i < LAT; i++) begin
        dv[i] <= dv[i-1];
        dx[i] <= dx[i-1];
        dy[i] <= dy[i-1];
      end

      grad_valid <= dv[LAT-1];
      if (dv[LAT-1]) begin
        grad_out <= eq_grad;
        grad_x   <= dx[LAT-1];
        grad_y   <= dy[LAT-1];
      end

      if (accept) begin
        for (int r = 0; r < 5; r++) begin
          for (int c = 0; c < 4; c++) begin
            win[r][c] <= win[r][c+1];
          end
          win[r][4] <= new_col[r];
        end
      end

      case (state)
        S_IDLE: begin
          if (frame_start) begin
            state <= S_RUN;
            col   <= '0;
            row   <= '0;
          end
        end
        S_RUN: begin
          if (accept) begin
            if (col_last) begin
              col <= '0;
              row <= row + CW'(1);
              if (row_last) begin
                state <= S_DRAIN;
              end
            end else begin
              col <= col + CW'(1);
            end
          end
        end
        S_DRAIN: begin
          if (!pipe_busy_next) begin
            state <= S_DONE;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/equ1_frame_seq.md
Name: equ1_frame_seq

Overview:
- Streaming sequencer for the `equ1` gradient datapath.
- Accepts a raster-order 12-bit CFA pixel stream, one frame at a time.
- Holds 4 line buffers plus a 5x5 register window, and drives the 25 `equ1` tap inputs with a `start` pulse for every interior window.
- Tracks `equ1`'s fixed pipeline latency and returns each 8-bit `grad_abs_out` tagged with its centre coordinate.

Parameters:
- IMG_W, 8, frame width in pixels (>=5)
- IMG_H, 6, frame height in lines (>=5)
- PW, 12, pixel width; matches `equ1` tap width
- LAT, 3, `equ1` cycles from `start` to valid `grad_abs_out`
- CW, 10, coordinate counter width

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-low reset
- frame_start  in  1  one-cycle pulse; begins a frame when IDLE
- in_valid  in  1  pixel valid
- in_ready  out  1  pixel accepted when in_valid & in_ready
- in_pix  in  PW  pixel, raster order
- eq_start  out  1  to `equ1` start
- eq_win  out  25*PW  taps; slice k = (r-1)*5+(c-1) drives e{r}t{c}; e1 = oldest row, t1 = leftmost column
- eq_grad  in  8  from `equ1` grad_abs_out
- grad_valid  out  1  one-cycle result strobe
- grad_out  out  8  registered gradient
- grad_x  out  CW  centre column of result
- grad_y  out  CW  centre row of result
- busy  out  1  high in RUN or DRAIN
- frame_done  out  1  one-cycle pulse at end of frame

Behaviour:
- Reset (rst==0 at clk edge) values:
  - state=IDLE; all counters 0; valid-delay line cleared.
  - in_ready, eq_start, grad_valid, busy, frame_done = 0.
  - grad_out, grad_x, grad_y, eq_win = 0.
  - Line-buffer contents need not be cleared.
- States:
  - IDLE: in_ready=0. frame_start -> RUN; col=row=0.
  - RUN: in_ready=1. Each accepted pixel advances col; col wraps IMG_W-1 -> 0 and increments row. Accepting pixel (IMG_W-1, IMG_H-1) -> DRAIN.
  - DRAIN: in_ready=0. Waits until the delay line is empty (LAT cycles after the last eq_start), then -> DONE.
  - DONE: frame_done=1 for exactly 1 cycle -> IDLE.
- Window update on each accept:
  - Window shifts left one column.
  - New column t5 = line buffers at current col (rows row-4..row-1) with in_pix as e5.
  - in_pix is written into the line buffer for the current row, overwriting the oldest line.
- Start generation:
  - eq_start=1 in the cycle after accepting pixel (col,row) with col>=4 and row>=4.
  - eq_win is updated in that same cycle and held stable until the next accept.
  - Window centre = (col-2, row-2).
  - Border windows produce no start; no padding.
  - Starts per frame = (IMG_W-4)*(IMG_H-4).
- Result path:
  - eq_start and the centre coordinates go into a LAT-deep delay line.
  - LAT cycles after eq_start: grad_valid=1, grad_out=eq_grad, grad_x/grad_y = delayed centre.
  - No downstream backpressure.
- Stalls: in_valid=0 freezes the counters and the window. eq_start is never asserted without an accept.
- Ignored inputs:
  - frame_start while not IDLE is ignored.
  - in_valid outside RUN is ignored; nothing is written.
- Reset mid-frame: immediately returns to IDLE with all outputs at reset values. In-flight results are discarded; grad_valid stays low even if `equ1` still produces output.
- Back-to-back frames: frame_start is accepted in the cycle after frame_done. Line-buffer history from the previous frame never reaches a start, because of the row>=4 gate.
- Simultaneous events: the last accept and a delay-line exit in the same cycle are both honoured. The DRAIN->DONE check uses the post-update delay-line state.

Test Plan:
- Single frame, pixel = row*16+col, in_valid always 1:
  - First eq_start follows the 37th accept (pixel (4,4)); e1t1=0, e3t3=34, e5t5=68.
  - Exactly 8 starts in total.
  - Results in order (2,2),(3,2),(4,2),(5,2),(2,3)..(5,3).
- `equ1` model returning eq_grad = low byte of e3t3:
  - Each grad_valid arrives exactly LAT=3 cycles after its eq_start.
  - Result at centre (3,2) has grad_out=35.
- in_valid toggling 1,0,0,1,... through the frame:
  - Identical window contents and result order as the first test.
  - No eq_start in any cycle without a preceding accept.
- frame_start pulsed during RUN and during DRAIN:
  - Ignored: counters unchanged, single frame_done.
  - Second frame_start the cycle after frame_done starts a fresh frame with 8 results.
- rst=0 for one cycle after 40 accepts:
  - All outputs 0 next cycle; no grad_valid for the 3 in-flight starts.
  - Subsequent full frame is correct.
- Final-cycle timing:
  - frame_done asserts 1 cycle after the grad_valid for (5,3).
  - busy falls in the same cycle frame_done rises.
